poly_block_stats: RTL

Downstream consumer of the pipelined polynomial evaluator's y stream. It accumulates blocks of N signed samples and reports sum, min, max and sample count for each block. Results are emitted over a valid/ready output handshake, and an early flush closes a partial block. Input samples are qualified by in_valid, which is the evaluator's input strobe delayed by the evaluator's 3-cycle latency.

---
 rtl/poly_block_stats.sv | 134 +++++++++++++
 1 files changed

// File: rtl/poly_block_stats.sv
`default_nettype none
// ============================================================================
// poly_block_stats : per-block sum/min/max/count of a signed sample stream
// Revision 1.0
// ============================================================================
module poly_block_stats #(
  parameter int WIDTH     = 16,
  parameter int N         = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     in_data,
  output logic                        in_ready,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_sum,
  output logic signed [WIDTH-1:0]     out_min,
  output logic signed [WIDTH-1:0]     out_max,
  output logic [$clog2(N+1)-1:0]      out_count,
  output logic                        out_sat
);

  localparam int CW = $clog2(N+1);
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [WIDTH-1:0]      mn;
  logic signed [WIDTH-1:0]      mx;
  logic [CW-1:0]                cnt;
  logic                         sat;

  logic [ACC_WIDTH:0]           acc_ext;
  logic [ACC_WIDTH:0]           smp_ext;
  logic [ACC_WIDTH:0]           sum_w;
  logic                         ovf;
  logic                         accept;
  logic                         first;
  logic                         close;
  logic signed [ACC_WIDTH-1:0]  n_acc;
  logic signed [WIDTH-1:0]      n_min;
  logic signed [WIDTH-1:0]      n_max;
  logic [CW-1:0]                n_cnt;
  logic                         n_sat;

  // One guard bit above the accumulator detects overflow of a single add
  always_comb begin
    acc_ext = {acc[ACC_WIDTH-1], acc};
    smp_ext = {{(ACC_WIDTH+1-WIDTH){in_data[WIDTH-1]}}, in_data};
    sum_w   = acc_ext + smp_ext;
    ovf     = sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1];
    accept  = in_valid && in_ready && (state == ACCUM);
    first   = (cnt == '0);

    n_acc = acc;
    n_min = mn;
    n_max = mx;
    n_cnt = cnt;
    n_sat = sat;
    if (accept) begin
      if (ovf) n_acc = sum_w[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
      else     n_acc = sum_w[ACC_WIDTH-1:0];
      n_sat = sat | ovf;
      n_min = (first || in_data < mn) ? in_data : mn;
      n_max = (first || in_data > mx) ? in_data : mx;
      n_cnt = cnt + CW'(1);
    end

    close = (state == ACCUM) &&
            ((accept && n_cnt == CW'(N)) || (flush && n_cnt != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      acc       <= '0;
      mn        <= '0;
      mx        <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_sum   <= '0;
      out_min   <= '0;
      out_max   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          acc <= n_acc;
          mn  <= n_min;
          mx  <= n_max;
          cnt <= n_cnt;
          sat <= n_sat;
          if (close) begin
            out_sum   <= n_acc;
            out_min   <= n_min;
            out_max   <= n_max;
            out_count <= n_cnt;
            out_sat   <= n_sat;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= HOLD;
          end else begin
            in_ready  <= 1'b1;
          end
        end
        HOLD: begin
          // out_* deliberately keep their values after the handshake
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            acc       <= '0;
            mn        <= '0;
            mx        <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
`default_nettype wire
